// File: rtl/tdpsram_bypass.sv
// rtl/tdpsram_bypass.sv - true dual-port byte-lane SRAM with collision resolution and clear engine
// Define TDPSRAM_BYPASS_EN for cross-port write-first reads; otherwise cross-port reads are read-first.
module tdpsram_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int BYTE_SIZE = 8,
  parameter int OUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int NL = DATA_WIDTH / BYTE_SIZE,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  collision_o,
  input  logic [AW-1:0]         addr0_i,
  input  logic [AW-1:0]         addr1_i,
  input  logic                  en0_i,
  input  logic                  en1_i,
  input  logic [NL-1:0]         we0_i,
  input  logic [NL-1:0]         we1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  typedef enum logic [1:0] {S_CLEAR, S_READY, S_FLUSH} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(DATA_DEPTH - 1);

  state_t                  state, state_nxt;
  logic [AW:0]             cnt, cnt_nxt;
  logic                    clearing;
  logic                    en0, en1, same_addr;
  logic [NL-1:0]           wl0, wl1;
  logic [DATA_WIDTH-1:0]   old0, old1, rd0_nxt, rd1_nxt;
  logic [DATA_WIDTH-1:0]   rd0_q, rd1_q;
  logic [DATA_WIDTH-1:0]   mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_CLEAR, S_FLUSH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_READY;
      end
      S_READY: begin
        if (flush_i) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready_o   = (state == S_READY);
  assign clearing  = (state == S_CLEAR) || (state == S_FLUSH);
  assign en0       = en0_i & ready_o;
  assign en1       = en1_i & ready_o;
  assign wl0       = en0 ? we0_i : '0;
  assign wl1       = en1 ? we1_i : '0;
  assign same_addr = (addr0_i == addr1_i);
  assign old0      = mem[addr0_i];
  assign old1      = mem[addr1_i];

  // Lane-wise read view; port 1 data is the final value on lanes both ports wrote.
  always_comb begin
    rd0_nxt = old0;
    rd1_nxt = old1;
    for (int l = 0; l < NL; l++) begin
`ifdef TDPSRAM_BYPASS_EN
      if (same_addr && wl1[l])
        rd0_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata1_i[l*BYTE_SIZE +: BYTE_SIZE];
      else if (wl0[l])
        rd0_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata0_i[l*BYTE_SIZE +: BYTE_SIZE];
      if (wl1[l])
        rd1_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata1_i[l*BYTE_SIZE +: BYTE_SIZE];
      else if (same_addr && wl0[l])
        rd1_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata0_i[l*BYTE_SIZE +: BYTE_SIZE];
`else
      if (wl0[l])
        rd0_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata0_i[l*BYTE_SIZE +: BYTE_SIZE];
      if (wl1[l])
        rd1_nxt[l*BYTE_SIZE +: BYTE_SIZE] = wdata1_i[l*BYTE_SIZE +: BYTE_SIZE];
`endif
    end
  end

  // Port 1 lane writes are issued last so they win on overlap.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[cnt[AW-1:0]] <= INIT_VALUE;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (wl0[l]) mem[addr0_i][l*BYTE_SIZE +: BYTE_SIZE] <= wdata0_i[l*BYTE_SIZE +: BYTE_SIZE];
        if (wl1[l]) mem[addr1_i][l*BYTE_SIZE +: BYTE_SIZE] <= wdata1_i[l*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q       <= '0;
      rd1_q       <= '0;
      collision_o <= 1'b0;
    end else begin
      if (en0) rd0_q <= rd0_nxt;
      if (en1) rd1_q <= rd1_nxt;
      collision_o <= en0 & en1 & same_addr & (|(we0_i & we1_i));
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  ld0_q, ld1_q;
      logic [DATA_WIDTH-1:0] rd0_qq, rd1_qq;
      always_ff @(posedge clk) begin
        if (rst) begin
          ld0_q  <= 1'b0;
          ld1_q  <= 1'b0;
          rd0_qq <= '0;
          rd1_qq <= '0;
        end else begin
          ld0_q <= en0;
          ld1_q <= en1;
          if (ld0_q) rd0_qq <= rd0_q;
          if (ld1_q) rd1_qq <= rd1_q;
        end
      end
      assign rdata0_o = rd0_qq;
      assign rdata1_o = rd1_qq;
    end else begin : g_noreg
      assign rdata0_o = rd0_q;
      assign rdata1_o = rd1_q;
    end
  endgenerate

endmodule
